// File: rtl/sar_search.sv
// Successive-approximation search engine driving the B operand of a combinational
// magnitude comparator and converging on the unknown A value, one compare per clock.
module sar_search #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       cmp_code,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [3:0]       steps
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, PROBE} state_t;

    state_t           state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [WIDTH-1:0] probe_n, result_n, adj;
    logic             busy_n, done_n, err_n;
    logic [3:0]       steps_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= IW'(WIDTH - 1);
            probe  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            steps  <= '0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            probe  <= probe_n;
            result <= result_n;
            busy   <= busy_n;
            done   <= done_n;
            err    <= err_n;
            steps  <= steps_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        probe_n  = probe;
        result_n = result;
        busy_n   = busy;
        done_n   = 1'b0;
        err_n    = err;
        steps_n  = steps;
        // trial bit survives only when the target is above the probe
        adj      = probe;
        if (cmp_code == 2'b10)
            adj[idx] = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    probe_n            = '0;
                    probe_n[WIDTH-1]   = 1'b1;
                    idx_n              = IW'(WIDTH - 1);
                    steps_n            = '0;
                    err_n              = 1'b0;
                    busy_n             = 1'b1;
                    state_n            = PROBE;
                end
            end
            PROBE: begin
                steps_n = steps + 4'd1;
                case (cmp_code)
                    2'b00: begin
                        result_n = probe;
                        done_n   = 1'b1;
                        busy_n   = 1'b0;
                        state_n  = IDLE;
                    end
                    2'b11: begin
                        err_n    = 1'b1;
                        result_n = '0;
                        done_n   = 1'b1;
                        busy_n   = 1'b0;
                        state_n  = IDLE;
                    end
                    default: begin
                        if (idx != '0) begin
                            probe_n                = adj;
                            probe_n[idx - IW'(1)]  = 1'b1;
                            idx_n                  = idx - IW'(1);
                        end else begin
                            result_n = adj;
                            done_n   = 1'b1;
                            busy_n   = 1'b0;
                            state_n  = IDLE;
                        end
                    end
                endcase
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search with a behavioural 8-bit comparator on the probe.
module tb_sar_search;

    logic       clk = 1'b0;
    logic       rst, start, force_ill;
    logic [1:0] cmp_code;
    logic [7:0] probe, result, target;
    logic       busy, done, err;
    logic [3:0] steps;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] seen [16];
    int         nprobes;

    sar_search #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cmp_code(cmp_code),
        .probe(probe), .busy(busy), .done(done), .result(result),
        .err(err), .steps(steps)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (force_ill)             cmp_code = 2'b11;
        else if (target == probe)  cmp_code = 2'b00;
        else if (target > probe)   cmp_code = 2'b01;
        else                       cmp_code = 2'b10;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts a search, records every probe while busy, returns compare-to-done latency.
    // poke >= 0 raises start for one cycle mid-search.
    task automatic do_search(input logic [7:0] t, input int poke, output int lat);
        target = t;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        lat = 0;
        nprobes = 0;
        while (!done && lat < 20) begin
            if (busy && nprobes < 16) begin
                seen[nprobes] = probe;
                nprobes++;
            end
            start = (lat == poke);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("timeout", 32'(lat < 20), 32'd1);
    endtask

    typedef struct {
        logic [7:0] target;
        logic [7:0] exp_result;
        logic [3:0] exp_steps;
    } vec_t;

    initial begin
        vec_t       vecs [8];
        logic [7:0] seq_5a [7];
        logic [7:0] seq_ff [8];
        logic [7:0] seq_33 [8];
        int         lat;
        int         guard;

        vecs[0] = '{8'h5A, 8'h5A, 4'd7};
        vecs[1] = '{8'h80, 8'h80, 4'd1};
        vecs[2] = '{8'hFF, 8'hFF, 4'd8};
        vecs[3] = '{8'h00, 8'h00, 4'd8};
        vecs[4] = '{8'h01, 8'h01, 4'd8};
        vecs[5] = '{8'h40, 8'h40, 4'd2};
        vecs[6] = '{8'hC3, 8'hC3, 4'd8};
        vecs[7] = '{8'hA0, 8'hA0, 4'd3};
        seq_5a = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};
        seq_ff = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
        seq_33 = '{8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h34, 8'h32, 8'h33};

        rst = 1'b1; start = 1'b0; force_ill = 1'b0; target = 8'h00;
        #3;
        chk("rst_probe", 32'(probe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_steps", 32'(steps), 32'h0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_search(vecs[i].target, -1, lat);
            chk("vec_result", 32'(result), 32'(vecs[i].exp_result));
            chk("vec_steps", 32'(steps), 32'(vecs[i].exp_steps));
            chk("vec_err", 32'(err), 32'h0);
            chk("vec_busy", 32'(busy), 32'h0);
            chk("vec_latency", 32'(lat), 32'(vecs[i].exp_steps));
            @(negedge clk);
            chk("vec_done_pulse", 32'(done), 32'h0);
        end

        do_search(8'h5A, -1, lat);
        chk("seq5a_len", 32'(nprobes), 32'd7);
        for (int i = 0; i < 7; i++) chk("seq5a_probe", 32'(seen[i]), 32'(seq_5a[i]));
        repeat (3) @(negedge clk);
        chk("idle_probe_hold", 32'(probe), 32'h5A);
        chk("idle_result_hold", 32'(result), 32'h5A);

        do_search(8'hFF, -1, lat);
        chk("seqff_len", 32'(nprobes), 32'd8);
        for (int i = 0; i < 8; i++) chk("seqff_probe", 32'(seen[i]), 32'(seq_ff[i]));

        // illegal code on the third compare
        target = 8'h5A;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("err_probe3", 32'(probe), 32'h60);
        force_ill = 1'b1;
        @(negedge clk);
        force_ill = 1'b0;
        chk("err_done", 32'(done), 32'h1);
        chk("err_flag", 32'(err), 32'h1);
        chk("err_result", 32'(result), 32'h0);
        chk("err_steps", 32'(steps), 32'd3);
        chk("err_busy", 32'(busy), 32'h0);
        // start while done is high is accepted and clears err
        target = 8'h33;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("restart_err", 32'(err), 32'h0);
        chk("restart_busy", 32'(busy), 32'h1);
        chk("restart_probe", 32'(probe), 32'h80);
        chk("restart_steps", 32'(steps), 32'h0);
        guard = 0;
        while (!done && guard < 20) begin @(negedge clk); guard++; end
        chk("restart_timeout", 32'(guard < 20), 32'd1);
        chk("restart_result", 32'(result), 32'h33);
        chk("restart_steps_end", 32'(steps), 32'd8);

        // async reset during the fourth compare
        target = 8'h5A;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_probe", 32'(probe), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        chk("arst_result", 32'(result), 32'h0);
        chk("arst_err", 32'(err), 32'h0);
        chk("arst_steps", 32'(steps), 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("arst_idle", 32'(busy), 32'h0);
        chk("arst_idle_probe", 32'(probe), 32'h0);

        do_search(8'h33, 3, lat);
        chk("ign_result", 32'(result), 32'h33);
        chk("ign_steps", 32'(steps), 32'd8);
        chk("ign_len", 32'(nprobes), 32'd8);
        for (int i = 0; i < 8; i++) chk("ign_probe", 32'(seen[i]), 32'(seq_33[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
